// File: rtl/mage_cfg_loader.sv
// Purpose : streams a Mage-CGRA config image (32-bit words) into consecutive register-bus writes from a base address.
// Latency : start -> first reg_valid_o in 2 cycles; 2 cycles/word (3 with readback); done_o one cycle after the last completion.
// Backpr. : cfg_ready_o only in FETCH; a bus request holds addr/data/valid until reg_ready_i. Optional readback: MAGE_CFG_LOADER_READBACK_EN.
module mage_cfg_loader #(
  parameter int AW = 32,
  parameter int CW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [CW-1:0] num_words_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [CW-1:0] words_done_o,
  input  logic [31:0]   cfg_data_i,
  input  logic          cfg_valid_i,
  output logic          cfg_ready_o,
  output logic [AW-1:0] reg_addr_o,
  output logic [31:0]   reg_wdata_o,
  output logic [3:0]    reg_wstrb_o,
  output logic          reg_write_o,
  output logic          reg_valid_o,
  input  logic          reg_ready_i,
  input  logic          reg_error_i,
  input  logic [31:0]   reg_rdata_i
);

`ifdef MAGE_CFG_LOADER_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WRITE  = 3'd2,
    S_READ   = 3'd3,
    S_FINISH = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WRITE  = 3'd2,
    S_FINISH = 3'd4
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          err_q, err_d;
  logic          abort_q, abort_d;
  logic          last_word;
  logic          abort_seen;

  assign cnt_inc    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
  // The word being completed is the last one when the count would reach the latched length.
  assign last_word  = (cnt_inc == num_q);
  // An abort raised while a bus request was stalled is remembered until that request completes.
  assign abort_seen = abort_q | abort_i;

`ifdef MAGE_CFG_LOADER_READBACK_EN
  logic rd_match;
  logic unused_base_lsb;
  assign rd_match        = (reg_rdata_i == wdata_q);
  assign unused_base_lsb = ^base_addr_i[1:0];
`else
  // Read data and the byte-offset address bits have no consumer in this build.
  logic unused_inputs;
  assign unused_inputs = ^{reg_rdata_i, base_addr_i[1:0]};
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (num_words_i == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort_i) begin
          state_d = S_FINISH;
        end else if (cfg_valid_i) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (reg_ready_i) begin
          if (reg_error_i) begin
            state_d = S_FINISH;
`ifdef MAGE_CFG_LOADER_READBACK_EN
          end else if (abort_seen) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_READ;
          end
`else
          end else if (abort_seen || last_word) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_FETCH;
          end
`endif
        end
      end
`ifdef MAGE_CFG_LOADER_READBACK_EN
      S_READ: begin
        if (reg_ready_i) begin
          if (reg_error_i || !rd_match || abort_seen || last_word) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_FINISH);
    // An abort in FETCH must not let a word slip through in the same cycle.
    cfg_ready_o = (state_q == S_FETCH) && !abort_i;
    reg_valid_o = 1'b0;
    reg_write_o = 1'b0;
    case (state_q)
      S_WRITE: begin
        reg_valid_o = 1'b1;
        reg_write_o = 1'b1;
      end
`ifdef MAGE_CFG_LOADER_READBACK_EN
      S_READ: begin
        reg_valid_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Datapath next-state: address, captured word, length, progress count and sticky flags
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = {base_addr_i[AW-1:2], 2'b00};
          num_d   = num_words_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (abort_i) begin
          err_d = 1'b1;
        end else if (cfg_valid_i) begin
          wdata_d = cfg_data_i;
        end
      end
      S_WRITE: begin
        if (abort_i) begin
          abort_d = 1'b1;
        end
        if (reg_ready_i) begin
          if (reg_error_i) begin
            err_d = 1'b1;
`ifdef MAGE_CFG_LOADER_READBACK_EN
          end else if (abort_seen) begin
            // Word is written but never verified, so it is not counted.
            err_d = 1'b1;
          end
`else
          end else begin
            // A completed write is counted even when an abort ends the load here.
            cnt_d = cnt_inc;
            if (abort_seen) begin
              err_d = 1'b1;
            end else if (!last_word) begin
              addr_d = addr_q + AW'(4);
            end
          end
`endif
        end
      end
`ifdef MAGE_CFG_LOADER_READBACK_EN
      S_READ: begin
        if (abort_i) begin
          abort_d = 1'b1;
        end
        if (reg_ready_i) begin
          if (reg_error_i || !rd_match) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (abort_seen) begin
              err_d = 1'b1;
            end else if (!last_word) begin
              addr_d = addr_q + AW'(4);
            end
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign error_o      = err_q;
  assign words_done_o = cnt_q;
  assign reg_addr_o   = addr_q;
  assign reg_wdata_o  = wdata_q;
  assign reg_wstrb_o  = 4'hF;

endmodule

// File: tb/tb_mage_cfg_loader.sv
// Bench for mage_cfg_loader: table of load scenarios with hand-derived results plus reset/error-clear sequences.
module tb_mage_cfg_loader;
  localparam int AW = 32;
  localparam int CW = 10;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          abort_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] num_words_i;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [CW-1:0] words_done_o;
  logic [31:0]   cfg_data_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [AW-1:0] reg_addr_o;
  logic [31:0]   reg_wdata_o;
  logic [3:0]    reg_wstrb_o;
  logic          reg_write_o;
  logic          reg_valid_o;
  logic          reg_ready_i;
  logic          reg_error_i;
  logic [31:0]   reg_rdata_i;

  always #5 clk_i = ~clk_i;

  mage_cfg_loader #(.AW(AW), .CW(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .num_words_i(num_words_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .words_done_o(words_done_o),
    .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_write_o(reg_write_o), .reg_valid_o(reg_valid_o), .reg_ready_i(reg_ready_i),
    .reg_error_i(reg_error_i), .reg_rdata_i(reg_rdata_i)
  );

  int total = 0;
  int bad   = 0;

  // One load scenario: stimulus knobs followed by the hand-derived outcome.
  // Cycle numbers count negedges from the one at which start_i is driven (cycle 0).
  typedef struct {
    logic [31:0] base;
    int          num;
    logic [31:0] dbase;     // stream word k carries dbase + k
    int          err_at;    // write index answered with reg_error_i (-1 none)
    int          stall_at;  // write index held off with reg_ready_i low
    int          stall_n;   // number of stalled cycles
    int          abort_cyc; // cycle on which abort_i pulses (-1 none)
    bit          rd_bad;    // readback returns 0xDEAD instead of the written word
    int          exp_words;
    bit          exp_err;
    int          exp_wr;    // completed write handshakes
    int          exp_rd;    // completed read handshakes
    int          exp_cons;  // stream words consumed
    logic [31:0] exp_last;  // address of the last write handshake
    int          exp_done;  // cycle in which done_o is high (-1 not checked)
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [31:0] base, int num, logic [31:0] dbase, int err_at,
                              int stall_at, int stall_n, int abort_cyc, bit rd_bad,
                              int exp_words, bit exp_err, int exp_wr, int exp_rd,
                              int exp_cons, logic [31:0] exp_last, int exp_done);
    vec_t v;
    v.base = base; v.num = num; v.dbase = dbase; v.err_at = err_at;
    v.stall_at = stall_at; v.stall_n = stall_n; v.abort_cyc = abort_cyc; v.rd_bad = rd_bad;
    v.exp_words = exp_words; v.exp_err = exp_err; v.exp_wr = exp_wr; v.exp_rd = exp_rd;
    v.exp_cons = exp_cons; v.exp_last = exp_last; v.exp_done = exp_done;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          cyc;
    int          sidx;
    int          n_wr;
    int          n_rd;
    int          n_done;
    int          done_cyc;
    int          stall_left;
    int          idx;
    logic [31:0] base_al;
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    logic [31:0] last_addr;
    logic [31:0] last_wd;
    base_al    = {v.base[31:2], 2'b00};
    sidx       = 0;
    n_wr       = 0;
    n_rd       = 0;
    n_done     = 0;
    done_cyc   = -1;
    stall_left = v.stall_n;
    last_addr  = '0;
    last_wd    = '0;
    cyc        = 0;
    @(negedge clk_i);
    base_addr_i = v.base;
    num_words_i = CW'(v.num);
    cfg_valid_i = 1'b1;
    while (cyc < 60 && !(n_done > 0 && cyc > done_cyc + 2)) begin
      start_i     = (cyc == 0);
      abort_i     = (cyc == v.abort_cyc);
      cfg_data_i  = v.dbase + sidx;
      reg_ready_i = 1'b1;
      reg_error_i = 1'b0;
      if (reg_valid_o && reg_write_o && n_wr == v.stall_at && stall_left > 0) begin
        reg_ready_i = 1'b0;
        stall_left--;
      end
      if (reg_valid_o && reg_write_o && n_wr == v.err_at) reg_error_i = reg_ready_i;
      reg_rdata_i = v.rd_bad ? 32'hDEAD : last_wd;
      #1;
      if (done_o) begin
        n_done++;
        done_cyc = cyc;
      end
      if (reg_valid_o) begin
        idx   = reg_write_o ? n_wr : n_wr - 1;
        exp_a = base_al + 32'(4 * idx);
        exp_d = v.dbase + 32'(idx);
        check($sformatf("%s/c%0d addr", tag, cyc), reg_addr_o, exp_a);
        if (reg_write_o) check($sformatf("%s/c%0d wdata", tag, cyc), reg_wdata_o, exp_d);
        check($sformatf("%s/c%0d cfg_ready", tag, cyc), cfg_ready_o, 1'b0);
        if (reg_ready_i) begin
          if (reg_write_o) begin
            n_wr++;
            last_addr = reg_addr_o;
            last_wd   = reg_wdata_o;
          end else begin
            n_rd++;
          end
        end
      end
      if (cfg_valid_i && cfg_ready_o) sidx++;
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    check({tag, "/done_pulses"}, n_done, 1);
    check({tag, "/words_done"}, words_done_o, CW'(v.exp_words));
    check({tag, "/error"}, error_o, v.exp_err);
    check({tag, "/busy_after"}, busy_o, 1'b0);
    check({tag, "/writes"}, n_wr, v.exp_wr);
    check({tag, "/reads"}, n_rd, v.exp_rd);
    check({tag, "/consumed"}, sidx, v.exp_cons);
    if (v.exp_wr > 0) check({tag, "/last_addr"}, last_addr, v.exp_last);
    if (v.exp_done >= 0) check({tag, "/done_cycle"}, done_cyc, v.exp_done);
  endtask

  initial begin
    logic got;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    base_addr_i = '0;
    num_words_i = '0;
    cfg_data_i  = '0;
    cfg_valid_i = 1'b0;
    reg_ready_i = 1'b0;
    reg_error_i = 1'b0;
    reg_rdata_i = '0;

`ifdef MAGE_CFG_LOADER_READBACK_EN
    tbl.push_back(mk(32'h80, 1, 32'hBEEF, -1, -1, 0, -1, 1'b1, 0, 1'b1, 1, 1, 1, 32'h80, 4));
    tbl.push_back(mk(32'h80, 2, 32'hBEEF, -1, -1, 0, -1, 1'b0, 2, 1'b0, 2, 2, 2, 32'h84, 7));
    tbl.push_back(mk(32'h300, 3, 32'h40, -1, 0, 6, 4, 1'b0, 0, 1'b1, 1, 0, 1, 32'h300, 9));
`else
    tbl.push_back(mk(32'h100, 3, 32'hA, -1, -1, 0, -1, 1'b0, 3, 1'b0, 3, 0, 3, 32'h108, 7));
    tbl.push_back(mk(32'h203, 2, 32'h50, -1, -1, 0, -1, 1'b0, 2, 1'b0, 2, 0, 2, 32'h204, 5));
    tbl.push_back(mk(32'h0, 4, 32'h10, 1, -1, 0, -1, 1'b0, 1, 1'b1, 2, 0, 2, 32'h4, 5));
    tbl.push_back(mk(32'hFFFF_FFF8, 3, 32'h77, -1, -1, 0, -1, 1'b0, 3, 1'b0, 3, 0, 3, 32'h0, 7));
    tbl.push_back(mk(32'h40, 3, 32'h20, -1, 1, 5, -1, 1'b0, 3, 1'b0, 3, 0, 3, 32'h48, 12));
    tbl.push_back(mk(32'h10, 1, 32'h99, -1, -1, 0, -1, 1'b0, 1, 1'b0, 1, 0, 1, 32'h10, 3));
    tbl.push_back(mk(32'h100, 0, 32'h1, -1, -1, 0, -1, 1'b0, 0, 1'b0, 0, 0, 0, 32'h0, -1));
    tbl.push_back(mk(32'h500, 2, 32'h30, -1, -1, 0, 3, 1'b0, 1, 1'b1, 1, 0, 1, 32'h500, 4));
    tbl.push_back(mk(32'h600, 2, 32'h31, -1, -1, 0, 1, 1'b0, 0, 1'b1, 0, 0, 0, 32'h0, 2));
    tbl.push_back(mk(32'h700, 1, 32'h32, -1, -1, 0, 2, 1'b0, 1, 1'b1, 1, 0, 1, 32'h700, 3));
    tbl.push_back(mk(32'h300, 3, 32'h40, -1, 0, 6, 4, 1'b0, 1, 1'b1, 1, 0, 1, 32'h300, 9));
`endif

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst/busy", busy_o, 1'b0);
    check("rst/done", done_o, 1'b0);
    check("rst/error", error_o, 1'b0);
    check("rst/cfg_ready", cfg_ready_o, 1'b0);
    check("rst/reg_valid", reg_valid_o, 1'b0);
    check("rst/reg_write", reg_write_o, 1'b0);
    check("rst/words_done", words_done_o, 0);
    check("rst/addr", reg_addr_o, 0);
    check("rst/wdata", reg_wdata_o, 0);
    check("rst/wstrb", reg_wstrb_o, 4'hF);
    rst_i = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // The last scenario left error_o set; a fresh start must clear it straight away.
    @(negedge clk_i);
    check("clr/error_sticky", error_o, 1'b1);
    base_addr_i = 32'h20;
    num_words_i = CW'(1);
    cfg_data_i  = 32'h5;
    cfg_valid_i = 1'b1;
    reg_ready_i = 1'b1;
    reg_error_i = 1'b0;
    reg_rdata_i = 32'h5;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("clr/error_cleared", error_o, 1'b0);
    check("clr/words_cleared", words_done_o, 0);
    check("clr/busy", busy_o, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk_i);
      if (done_o) got = 1'b1;
    end
    check("clr/done_seen", got, 1'b1);
    check("clr/words_done", words_done_o, 1);
    check("clr/error_final", error_o, 1'b0);

    // Reset in the middle of a stalled write drops everything at once.
    @(negedge clk_i);
    base_addr_i = 32'h900;
    num_words_i = CW'(3);
    reg_ready_i = 1'b0;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    check("mid/reg_valid", reg_valid_o, 1'b1);
    check("mid/addr", reg_addr_o, 32'h900);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid/busy", busy_o, 1'b0);
    check("mid/reg_valid_rst", reg_valid_o, 1'b0);
    check("mid/addr_rst", reg_addr_o, 0);
    check("mid/wdata_rst", reg_wdata_o, 0);
    check("mid/words_rst", words_done_o, 0);
    rst_i       = 1'b0;
    reg_ready_i = 1'b1;
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
